// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a small
// first-word-fall-through FIFO presented as a valid/ready byte stream.
module uart_rx_stream #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  input  logic                               RX,
  output logic [7:0]                         out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               frame_err,
  output logic                               overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // ---------------------------------------------------------------- sync
  logic       rx_meta_reg;
  logic       rx_s_reg;
  logic [1:0] sync_fill_reg;
  logic       sync_primed;

  // The flops come out of reset high, so rx_s only reflects the pin once both
  // stages have been refilled; until then a low line could look idle.
  assign sync_primed = (sync_fill_reg == 2'd2);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rx_meta_reg   <= 1'b1;
      rx_s_reg      <= 1'b1;
      sync_fill_reg <= 2'd0;
    end else begin
      rx_meta_reg <= RX;
      rx_s_reg    <= rx_meta_reg;
      if (!sync_primed) begin
        sync_fill_reg <= sync_fill_reg + 2'd1;
      end
    end
  end

  // ---------------------------------------------------------------- receiver
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             frame_err_reg, frame_err_next;
  logic             push;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg     <= WAIT_IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= 3'd0;
      shift_reg     <= 8'h00;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    frame_err_next = 1'b0;
    push           = 1'b0;

    case (state_reg)
      WAIT_IDLE: begin
        if (sync_primed && rx_s_reg) begin
          state_next = IDLE;
        end
      end

      IDLE: begin
        if (!rx_s_reg) begin
          cnt_next   = '0;
          state_next = START;
        end
      end

      START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next = '0;
          if (!rx_s_reg) begin
            bit_idx_next = 3'd0;
            state_next   = DATA;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next     = '0;
          shift_next   = {rx_s_reg, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (rx_s_reg) begin
            push       = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = WAIT_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      default: begin
        state_next = WAIT_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- fifo
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic             overrun_reg;
  logic             pop;
  logic             full;
  logic             push_ok;
  logic             push_drop;

  assign pop       = out_valid && out_ready;
  assign full      = (level_reg == LVL_FULL);
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push_ok   = push && (!full || pop);
  assign push_drop = push && full && !pop;

  always_ff @(posedge CLK) begin
    if (RST_N && push_ok) begin
      mem[wr_ptr_reg] <= shift_reg;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= push_drop;
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign out_valid  = (level_reg != '0);
  assign out_data   = out_valid ? mem[rd_ptr_reg] : 8'h00;
  assign fifo_level = level_reg;
  assign frame_err  = frame_err_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench for uart_rx_stream: stimulus pushes expected bytes into a
// queue, an independent monitor pops and compares on every accepted beat.
module tb_uart_rx_stream;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       RX = 1'b1;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic [2:0] fifo_level;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 CLK = ~CLK;

  uart_rx_stream #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .RX        (RX),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fifo_level(fifo_level),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic drive_bit(input logic v);
    RX = v;
    repeat (CPB) @(negedge CLK);
  endtask

  // Called on a falling edge; returns on a falling edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    $display("sent byte 0x%02h stop=%0d", b, stop_bit);
  endtask

  // Monitor / scoreboard
  initial begin
    logic       prev_hold;
    logic [7:0] prev_data;
    logic       prev_pulse;
    logic [7:0] e;
    prev_hold  = 1'b0;
    prev_data  = 8'h00;
    prev_pulse = 1'b0;
    forever begin
      @(negedge CLK);
      #1;
      if (out_valid && prev_hold) check("hold_stable", out_data, prev_data);
      if (out_valid && out_ready) begin
        beats++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got 0x%02h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", out_data, e);
          $display("beat %0d data=0x%02h expected=0x%02h", beats, out_data, e);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      if (frame_err || overrun) begin
        check("pulse_exclusive", frame_err && overrun, 0);
        check("pulse_single", prev_pulse, 0);
      end
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      prev_pulse = frame_err || overrun;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N = 1'b0;
    RX = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_valid", out_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_data", out_data, 0);
    RST_N = 1'b1;
    repeat (8) @(negedge CLK);

    // Single byte with latency check: stop sample is 154 edges after start.
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (154) @(posedge CLK);
        @(negedge CLK);
        check("valid_early", out_valid, 0);
        @(negedge CLK);
        check("valid_latency", out_valid, 1);
        check("latency_data", out_data, 8'hA5);
      end
    join
    repeat (4) @(negedge CLK);
    check("single_drained", exp_q.size(), 0);
    check("single_no_err", fe_cnt + ov_cnt, 0);

    // Back-to-back bytes
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55); exp_q.push_back(8'h3C);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    send_frame(8'h3C, 1'b1);
    repeat (20) @(negedge CLK);
    check("b2b_drained", exp_q.size(), 0);
    check("b2b_no_err", fe_cnt + ov_cnt, 0);

    // Framing error then line held low
    send_frame(8'h81, 1'b0);
    RX = 1'b0;
    repeat (40) @(negedge CLK);
    check("ferr_count", fe_cnt, 1);
    check("ferr_level", fifo_level, 0);
    check("ferr_valid", out_valid, 0);
    RX = 1'b1;
    repeat (CPB) @(negedge CLK);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    repeat (20) @(negedge CLK);
    check("ferr_recover", exp_q.size(), 0);
    check("ferr_count_after", fe_cnt, 1);

    // Overrun
    out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) exp_q.push_back(8'(v));
      send_frame(8'(v), 1'b1);
    end
    repeat (4) @(negedge CLK);
    check("ovr_level", fifo_level, 4);
    check("ovr_count", ov_cnt, 1);
    check("ovr_head", out_data, 8'h01);
    out_ready = 1'b1;
    repeat (10) @(negedge CLK);
    check("ovr_drained", exp_q.size(), 0);
    check("ovr_level_empty", fifo_level, 0);

    // Full FIFO with a pop in the push cycle
    out_ready = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      exp_q.push_back(8'(v));
      send_frame(8'(v), 1'b1);
    end
    check("simul_full", fifo_level, 4);
    exp_q.push_back(8'h05);
    fork
      send_frame(8'h05, 1'b1);
      begin
        repeat (154) @(posedge CLK);
        @(negedge CLK);
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
      end
    join
    repeat (2) @(negedge CLK);
    check("simul_no_overrun", ov_cnt, 1);
    check("simul_level", fifo_level, 4);
    out_ready = 1'b1;
    repeat (10) @(negedge CLK);
    check("simul_drained", exp_q.size(), 0);

    // Glitch
    out_ready = 1'b0;
    RX = 1'b0;
    repeat (3) @(negedge CLK);
    RX = 1'b1;
    repeat (30) @(negedge CLK);
    check("glitch_level", fifo_level, 0);
    check("glitch_valid", out_valid, 0);

    // Reset mid-frame with two bytes buffered (these are flushed, never expected)
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check("pre_rst_level", fifo_level, 2);
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (132) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("post_rst_valid", out_valid, 0);
        check("post_rst_level", fifo_level, 0);
      end
    join
    repeat (20) @(negedge CLK);
    check("no_partial_level", fifo_level, 0);
    out_ready = 1'b1;
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1);
    repeat (20) @(negedge CLK);
    check("final_drained", exp_q.size(), 0);
    check("final_fe", fe_cnt, 1);
    check("final_ov", ov_cnt, 1);
    check("beat_total", beats, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
